// File: rtl/axis_ser.sv
// AXI-Stream word serializer: buffers words in a FIFO, then shifts each out MSB-first
// with a strobe per bit. Define AXIS_SER_PARITY_EN to append an even-parity bit per word.
module axis_ser #(
    parameter int AXIS_NUM_BYTES = 4,
    parameter int FIFO_DEPTH     = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        tvalid_i,
    output logic                        tready_o,
    input  logic [AXIS_NUM_BYTES*8-1:0] tdata_i,
    input  logic                        tlast_i,
    input  logic [AXIS_NUM_BYTES-1:0]   tkeep_i,
    input  logic                        tuser_i,
    input  logic [15:0]                 bit_period_i,
    output logic                        serial_o,
    output logic                        serial_valid_o,
    output logic                        packet_done_o,
    output logic                        busy_o
);

    localparam int NBITS = AXIS_NUM_BYTES * 8;
    localparam int BCW   = $clog2(NBITS) + 1;
    localparam int PW    = $clog2(FIFO_DEPTH);
    localparam int CW    = PW + 1;

`ifdef AXIS_SER_PARITY_EN
    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, PARITY} state_t;
`else
    typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;
`endif

    // FIFO storage: {tlast, tdata}
    logic [NBITS:0]   r_mem [FIFO_DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_ready_en;

    state_t           r_state;
    logic [NBITS-1:0] r_shift;
    logic [BCW-1:0]   r_bits_left;
    logic [15:0]      r_cnt;
    logic [15:0]      r_period;
    logic             r_last;
    logic             r_serial;
    logic             r_serial_valid;
    logic             r_done_pend;
    logic             r_packet_done;
`ifdef AXIS_SER_PARITY_EN
    logic             r_parity;
`endif

    logic             w_push;
    logic             w_pop;
    logic             w_word_end;
    logic [NBITS:0]   w_head;
    logic [15:0]      w_period_m1;
    logic             w_unused;

    assign w_unused    = ^{tkeep_i, tuser_i};
    assign w_head      = r_mem[r_rd_ptr];
    assign tready_o    = r_ready_en && (r_count != CW'(FIFO_DEPTH));
    assign w_push      = tvalid_i && tready_o;
    assign w_period_m1 = (bit_period_i == 16'd0) ? 16'd0 : bit_period_i - 16'd1;

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        w_word_end = 1'b0;
        w_pop      = 1'b0;
`ifdef AXIS_SER_PARITY_EN
        w_word_end = (r_state == PARITY) && (r_cnt == 16'd0);
`else
        w_word_end = (r_state == SHIFT) && (r_cnt == 16'd0) && (r_bits_left == BCW'(1));
`endif
        // A word ending with data waiting pops the next one in the same cycle: no gap.
        w_pop = (r_state == LOAD) || (w_word_end && (r_count != '0));
    end

    // NOTE: the storage array has no reset; pointers and count alone define what is valid.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= {tlast_i, tdata_i};
    end

    // NOTE: sequential state uses <= so every register samples values from before the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_ready_en <= 1'b0;
        end else begin
            r_ready_en <= 1'b1;
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= IDLE;
            r_shift        <= '0;
            r_bits_left    <= '0;
            r_cnt          <= '0;
            r_period       <= '0;
            r_last         <= 1'b0;
            r_serial       <= 1'b0;
            r_serial_valid <= 1'b0;
            r_done_pend    <= 1'b0;
            r_packet_done  <= 1'b0;
`ifdef AXIS_SER_PARITY_EN
            r_parity       <= 1'b0;
`endif
        end else begin
            r_serial_valid <= 1'b0;
            r_done_pend    <= 1'b0;
            r_packet_done  <= r_done_pend;

            case (r_state)
                IDLE: begin
                    r_serial <= 1'b0;
                    if (r_count != '0) r_state <= LOAD;
                end
                LOAD: ;
                SHIFT: begin
                    if (r_cnt == 16'd0) begin
                        r_serial       <= r_shift[NBITS-1];
                        r_serial_valid <= 1'b1;
                        r_shift        <= {r_shift[NBITS-2:0], 1'b0};
                        r_bits_left    <= r_bits_left - BCW'(1);
                        r_cnt          <= r_period;
                        if (r_bits_left == BCW'(1)) begin
`ifdef AXIS_SER_PARITY_EN
                            r_state <= PARITY;
`else
                            r_done_pend <= r_last;
                            if (!w_pop) r_state <= IDLE;
`endif
                        end
                    end else begin
                        r_cnt <= r_cnt - 16'd1;
                    end
                end
`ifdef AXIS_SER_PARITY_EN
                PARITY: begin
                    if (r_cnt == 16'd0) begin
                        r_serial       <= r_parity;
                        r_serial_valid <= 1'b1;
                        r_done_pend    <= r_last;
                        if (!w_pop) r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt - 16'd1;
                    end
                end
`endif
                default: r_state <= IDLE;
            endcase

            // Word load overrides the shift/counter updates above; the bit period is
            // captured here and stays fixed for the whole word.
            if (w_pop) begin
                r_shift     <= w_head[NBITS-1:0];
                r_last      <= w_head[NBITS];
                r_period    <= w_period_m1;
                r_bits_left <= BCW'(NBITS);
                r_cnt       <= (r_state == LOAD) ? 16'd0 : w_period_m1;
                r_state     <= SHIFT;
`ifdef AXIS_SER_PARITY_EN
                r_parity    <= ^w_head[NBITS-1:0];
`endif
            end
        end
    end

    assign serial_o       = r_serial;
    assign serial_valid_o = r_serial_valid;
    assign packet_done_o  = r_packet_done;
    assign busy_o         = (r_count != '0) || (r_state != IDLE);

endmodule

// File: tb/tb_axis_ser.sv
// Directed bench for axis_ser: records every strobe (bit + cycle) and packet_done pulse,
// then checks each scenario against hand-computed words and timings.
module tb_axis_ser;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tvalid_i = 1'b0;
    logic        tready_o;
    logic [31:0] tdata_i = '0;
    logic        tlast_i = 1'b0;
    logic [3:0]  tkeep_i = 4'hF;
    logic        tuser_i = 1'b0;
    logic [15:0] bit_period_i = 16'd1;
    logic        serial_o;
    logic        serial_valid_o;
    logic        packet_done_o;
    logic        busy_o;

    axis_ser #(.AXIS_NUM_BYTES(4), .FIFO_DEPTH(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .tvalid_i       (tvalid_i),
        .tready_o       (tready_o),
        .tdata_i        (tdata_i),
        .tlast_i        (tlast_i),
        .tkeep_i        (tkeep_i),
        .tuser_i        (tuser_i),
        .bit_period_i   (bit_period_i),
        .serial_o       (serial_o),
        .serial_valid_o (serial_valid_o),
        .packet_done_o  (packet_done_o),
        .busy_o         (busy_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    bit sbits[$];
    int scyc[$];
    int dcyc[$];

    always @(posedge clk) begin
        #1;
        if (serial_valid_o) begin
            sbits.push_back(serial_o);
            scyc.push_back(cyc);
        end
        if (packet_done_o) dcyc.push_back(cyc);
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic clear_mon();
        sbits.delete();
        scyc.delete();
        dcyc.delete();
    endtask

    function automatic logic [31:0] get_word(input int idx);
        logic [31:0] w;
        w = '0;
        for (int i = 0; i < 32; i++) begin
            if (idx * 32 + i < sbits.size()) w = {w[30:0], sbits[idx*32+i]};
            else                             w = {w[30:0], 1'b0};
        end
        return w;
    endfunction

    function automatic int gap_errs(input int from, input int to, input int gap);
        int e;
        e = 0;
        if (to >= scyc.size()) e++;
        for (int i = from + 1; i <= to && i < scyc.size(); i++)
            if (scyc[i] - scyc[i-1] != gap) e++;
        return e;
    endfunction

    // Leaves tvalid_i high on return so consecutive calls present words back-to-back.
    task automatic send_word(input logic [31:0] d, input logic l, output int acc);
        @(negedge clk);
        tvalid_i = 1'b1;
        tdata_i  = d;
        tlast_i  = l;
        acc      = -1;
        for (int b = 0; b < 200; b++) begin
            #1;
            if (tready_o) begin
                acc = cyc + 1;
                break;
            end
            @(negedge clk);
        end
        n_vec++;
        if (acc < 0) begin
            n_err++;
            $display("FAIL send_word accept timeout data=%h", d);
        end
        @(posedge clk);
    endtask

    task automatic drop_valid();
        @(negedge clk);
        tvalid_i = 1'b0;
        tlast_i  = 1'b0;
    endtask

    task automatic wait_strobes(input int n, input int budget, input string tag);
        int k;
        k = 0;
        while (sbits.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        n_vec++;
        if (sbits.size() < n) begin
            n_err++;
            $display("FAIL %s strobe timeout got %0d want %0d", tag, sbits.size(), n);
        end
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int k;
        k = 0;
        while (busy_o && k < budget) begin
            @(negedge clk);
            k++;
        end
        n_vec++;
        if (busy_o !== 1'b0) begin
            n_err++;
            $display("FAIL %s busy_o stuck got %b want 0", tag, busy_o);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_vec += 5;
        if (tready_o !== 1'b0)       begin n_err++; $display("FAIL reset.tready got %b want 0", tready_o); end
        if (serial_o !== 1'b0)       begin n_err++; $display("FAIL reset.serial got %b want 0", serial_o); end
        if (serial_valid_o !== 1'b0) begin n_err++; $display("FAIL reset.valid got %b want 0", serial_valid_o); end
        if (packet_done_o !== 1'b0)  begin n_err++; $display("FAIL reset.done got %b want 0", packet_done_o); end
        if (busy_o !== 1'b0)         begin n_err++; $display("FAIL reset.busy got %b want 0", busy_o); end
        rst = 1'b0;
        #1;
        n_vec++;
        if (tready_o !== 1'b0) begin n_err++; $display("FAIL reset.tready_before_edge got %b want 0", tready_o); end
        @(negedge clk);
        n_vec++;
        if (tready_o !== 1'b1) begin n_err++; $display("FAIL reset.tready_after_edge got %b want 1", tready_o); end
    endtask

    task automatic test_single();
        int acc;
        logic [31:0] w;
        w = 32'hA500_0001;
        bit_period_i = 16'd1;
        clear_mon();
        send_word(w, 1'b1, acc);
        drop_valid();
        wait_strobes(32, 100, "single");
        wait_idle(50, "single");
        n_vec += 7;
        if (sbits.size() !== 32) begin n_err++; $display("FAIL single.count got %0d want 32", sbits.size()); end
        if (get_word(0) !== w)   begin n_err++; $display("FAIL single.word got %h want %h", get_word(0), w); end
        if (scyc.size() > 0 && scyc[0] !== acc + 3) begin
            n_err++; $display("FAIL single.latency got %0d want %0d", scyc[0] - acc, 3);
        end
        if (gap_errs(0, 31, 1) !== 0) begin n_err++; $display("FAIL single.spacing got %0d bad gaps want 0", gap_errs(0, 31, 1)); end
        if (dcyc.size() !== 1) begin n_err++; $display("FAIL single.done_count got %0d want 1", dcyc.size()); end
        if (dcyc.size() > 0 && scyc.size() == 32 && dcyc[0] !== scyc[31] + 1) begin
            n_err++; $display("FAIL single.done_time got %0d want %0d", dcyc[0], scyc[31] + 1);
        end
        if (serial_o !== 1'b0) begin n_err++; $display("FAIL single.idle_serial got %b want 0", serial_o); end
    endtask

    task automatic test_period_zero();
        int acc;
        logic [31:0] w;
        w = 32'h0000_FFFF;
        bit_period_i = 16'd0;
        clear_mon();
        send_word(w, 1'b0, acc);
        drop_valid();
        wait_strobes(32, 100, "period0");
        wait_idle(50, "period0");
        n_vec += 3;
        if (get_word(0) !== w) begin n_err++; $display("FAIL period0.word got %h want %h", get_word(0), w); end
        if (gap_errs(0, 31, 1) !== 0) begin n_err++; $display("FAIL period0.spacing got %0d bad gaps want 0", gap_errs(0, 31, 1)); end
        if (dcyc.size() !== 0) begin n_err++; $display("FAIL period0.no_done got %0d pulses want 0", dcyc.size()); end
    endtask

    task automatic test_back_to_back();
        int acc;
        logic [31:0] w [4];
        w[0] = 32'hDEAD_BEEF; w[1] = 32'h0123_4567; w[2] = 32'hFFFF_0000; w[3] = 32'h8000_0001;
        bit_period_i = 16'd1;
        clear_mon();
        for (int i = 0; i < 4; i++) send_word(w[i], (i == 3), acc);
        drop_valid();
        wait_strobes(128, 300, "b2b");
        wait_idle(50, "b2b");
        n_vec += 7;
        for (int i = 0; i < 4; i++)
            if (get_word(i) !== w[i]) begin n_err++; $display("FAIL b2b.word%0d got %h want %h", i, get_word(i), w[i]); end
        if (gap_errs(0, 127, 1) !== 0) begin n_err++; $display("FAIL b2b.spacing got %0d bad gaps want 0", gap_errs(0, 127, 1)); end
        if (dcyc.size() !== 1) begin n_err++; $display("FAIL b2b.done_count got %0d want 1", dcyc.size()); end
        if (dcyc.size() > 0 && scyc.size() >= 128 && dcyc[0] !== scyc[127] + 1) begin
            n_err++; $display("FAIL b2b.done_time got %0d want %0d", dcyc[0], scyc[127] + 1);
        end
    endtask

    task automatic test_period();
        int acc, acc2;
        bit_period_i = 16'd5;
        clear_mon();
        send_word(32'h8000_0000, 1'b1, acc);
        drop_valid();
        wait_strobes(3, 100, "period.start");
        @(negedge clk);
        bit_period_i = 16'd2;
        send_word(32'hC000_0000, 1'b1, acc2);
        drop_valid();
        wait_strobes(64, 600, "period");
        wait_idle(50, "period");
        n_vec += 7;
        if (get_word(0) !== 32'h8000_0000) begin n_err++; $display("FAIL period.word0 got %h want 80000000", get_word(0)); end
        if (get_word(1) !== 32'hC000_0000) begin n_err++; $display("FAIL period.word1 got %h want c0000000", get_word(1)); end
        if (scyc.size() > 0 && scyc[0] !== acc + 3) begin
            n_err++; $display("FAIL period.latency got %0d want 3", scyc[0] - acc);
        end
        if (gap_errs(0, 31, 5) !== 0)  begin n_err++; $display("FAIL period.spacing5 got %0d bad gaps want 0", gap_errs(0, 31, 5)); end
        if (gap_errs(31, 32, 2) !== 0) begin n_err++; $display("FAIL period.handoff got %0d bad gaps want 0", gap_errs(31, 32, 2)); end
        if (gap_errs(32, 63, 2) !== 0) begin n_err++; $display("FAIL period.spacing2 got %0d bad gaps want 0", gap_errs(32, 63, 2)); end
        if (dcyc.size() !== 2) begin n_err++; $display("FAIL period.done_count got %0d want 2", dcyc.size()); end
    endtask

    task automatic test_fifo_full();
        int sent, first_block, rises, k;
        logic prev_ready;
        logic [31:0] w [12];
        for (int i = 0; i < 12; i++) w[i] = 32'h1234_5678 ^ (i * 32'h0101_0101);
        bit_period_i = 16'd4;
        clear_mon();
        sent = 0; first_block = -1; rises = 0; k = 0; prev_ready = 1'b1;
        while (sent < 12 && k < 3000) begin
            @(negedge clk);
            k++;
            tvalid_i = 1'b1;
            tdata_i  = w[sent];
            tlast_i  = (sent == 11);
            #1;
            if (!tready_o && first_block < 0) first_block = sent;
            if (tready_o && !prev_ready) rises++;
            prev_ready = tready_o;
            if (tready_o) sent++;
        end
        drop_valid();
        wait_strobes(384, 2500, "fifo");
        wait_idle(50, "fifo");
        n_vec += 4;
        if (first_block !== 9) begin n_err++; $display("FAIL fifo.accepted_before_full got %0d want 9", first_block); end
        if (rises !== 3) begin n_err++; $display("FAIL fifo.ready_rises got %0d want 3", rises); end
        if (sent !== 12) begin n_err++; $display("FAIL fifo.sent got %0d want 12", sent); end
        if (dcyc.size() !== 1) begin n_err++; $display("FAIL fifo.done_count got %0d want 1", dcyc.size()); end
        for (int i = 0; i < 12; i++) begin
            n_vec++;
            if (get_word(i) !== w[i]) begin n_err++; $display("FAIL fifo.word%0d got %h want %h", i, get_word(i), w[i]); end
        end
    endtask

    task automatic test_reset_mid();
        int acc;
        bit_period_i = 16'd1;
        clear_mon();
        send_word(32'hFFFF_FFFF, 1'b1, acc);
        send_word(32'h1234_5678, 1'b1, acc);
        drop_valid();
        wait_strobes(10, 100, "rstmid");
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_vec++;
        if (tready_o !== 1'b0) begin n_err++; $display("FAIL rstmid.tready_in_reset got %b want 0", tready_o); end
        @(negedge clk);
        n_vec += 2;
        if (tready_o !== 1'b1) begin n_err++; $display("FAIL rstmid.tready_after got %b want 1", tready_o); end
        if (busy_o !== 1'b0)   begin n_err++; $display("FAIL rstmid.busy_after got %b want 0", busy_o); end
        repeat (40) @(negedge clk);
        n_vec += 3;
        if (sbits.size() !== 10) begin n_err++; $display("FAIL rstmid.strobes got %0d want 10", sbits.size()); end
        if (dcyc.size() !== 0)   begin n_err++; $display("FAIL rstmid.done got %0d want 0", dcyc.size()); end
        if (busy_o !== 1'b0)     begin n_err++; $display("FAIL rstmid.busy_idle got %b want 0", busy_o); end
        clear_mon();
        send_word(32'h8000_0001, 1'b1, acc);
        drop_valid();
        wait_strobes(32, 100, "rstmid.next");
        wait_idle(50, "rstmid.next");
        n_vec += 3;
        if (sbits.size() > 0 && sbits[0] !== 1'b1) begin n_err++; $display("FAIL rstmid.first_bit got %b want 1", sbits[0]); end
        if (get_word(0) !== 32'h8000_0001) begin n_err++; $display("FAIL rstmid.word got %h want 80000001", get_word(0)); end
        if (dcyc.size() !== 1) begin n_err++; $display("FAIL rstmid.done_count got %0d want 1", dcyc.size()); end
    endtask

`ifdef AXIS_SER_PARITY_EN
    task automatic test_parity();
        int acc;
        bit_period_i = 16'd1;
        clear_mon();
        send_word(32'h0000_0007, 1'b0, acc);
        drop_valid();
        wait_strobes(33, 100, "parity7");
        wait_idle(50, "parity7");
        n_vec += 3;
        if (sbits.size() !== 33) begin n_err++; $display("FAIL parity7.count got %0d want 33", sbits.size()); end
        if (get_word(0) !== 32'h0000_0007) begin n_err++; $display("FAIL parity7.word got %h want 7", get_word(0)); end
        if (sbits.size() > 32 && sbits[32] !== 1'b1) begin n_err++; $display("FAIL parity7.bit got %b want 1", sbits[32]); end
        clear_mon();
        send_word(32'h0000_0003, 1'b1, acc);
        drop_valid();
        wait_strobes(33, 100, "parity3");
        wait_idle(50, "parity3");
        n_vec += 3;
        if (sbits.size() !== 33) begin n_err++; $display("FAIL parity3.count got %0d want 33", sbits.size()); end
        if (sbits.size() > 32 && sbits[32] !== 1'b0) begin n_err++; $display("FAIL parity3.bit got %b want 0", sbits[32]); end
        if (dcyc.size() !== 1) begin n_err++; $display("FAIL parity3.done_count got %0d want 1", dcyc.size()); end
    endtask
`endif

    initial begin
        test_reset();
`ifdef AXIS_SER_PARITY_EN
        test_parity();
`else
        test_single();
        test_period_zero();
        test_back_to_back();
        test_period();
        test_fifo_full();
        test_reset_mid();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/axis_ser.md
AXIS_SER -- requirements
Module: axis_ser

Interface
REQ-001 SHALL have parameter AXIS_NUM_BYTES, default 4, AXIS stream word width in bytes (serial word = AXIS_NUM_BYTES*8 bits).
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, input word buffer depth, power of two, minimum 2.
REQ-003 SHALL have ports: clk  input  1  single clock, all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 tvalid_i  input  1  AXIS slave valid.
REQ-006 tready_o  output  1  AXIS slave ready.
REQ-007 tdata_i  input  AXIS_NUM_BYTES*8  AXIS slave data.
REQ-008 tlast_i  input  1  AXIS slave end of packet.
REQ-009 tkeep_i  input  AXIS_NUM_BYTES  ignored; every word is serialized in full.
REQ-010 tuser_i  input  1  ignored.
REQ-011 bit_period_i  input  16  clock cycles per serial bit; 0 treated as 1.
REQ-012 serial_o  output  1  serial data, MSB of each word first.
REQ-013 serial_valid_o  output  1  one-cycle strobe marking each valid bit on serial_o.
REQ-014 packet_done_o  output  1  one-cycle pulse after the final bit of a tlast word.
REQ-015 busy_o  output  1  high whenever FIFO non-empty or a word is being shifted.

Function
REQ-016 Word SHALL be accepted into the FIFO on any edge where tvalid_i and tready_o are both high; FIFO stores tdata_i and tlast_i.
REQ-017 tready_o SHALL be high exactly when the FIFO is not full, independent of tvalid_i; a pop in the same cycle does not raise tready_o that cycle.
REQ-018 FSM states: IDLE, LOAD, SHIFT, PARITY (PARITY only with macro, REQ-032).
REQ-019 IDLE -> LOAD when FIFO non-empty; LOAD pops one word into the shift register, latches its tlast and bit_period_i, -> SHIFT.
REQ-020 SHIFT SHALL emit AXIS_NUM_BYTES*8 bits MSB-first, each bit presented on serial_o with serial_valid_o high for exactly one cycle, strobes spaced max(bit_period_i,1) cycles apart.
REQ-021 serial_o SHALL hold the current bit value stable between strobes; in IDLE serial_o SHALL be 0.
REQ-022 Latency: with empty FIFO and IDLE, first strobe SHALL occur 3 clock cycles after the accepting edge.
REQ-023 Back-to-back: if the FIFO is non-empty at the final bit strobe of a word, the next word SHALL be popped in that cycle and its first strobe SHALL follow exactly one bit period later (no gap; with period 1, strobes on consecutive cycles).
REQ-024 After the final bit (or parity bit) with empty FIFO, FSM SHALL return to IDLE.
REQ-025 packet_done_o SHALL pulse high for one cycle, the cycle after the last strobe of a word latched with tlast=1; never otherwise.
REQ-026 bit_period_i changes SHALL take effect only at the next word load.
REQ-027 Bit counter SHALL be $clog2(AXIS_NUM_BYTES*8)+1 bits wide, period counter 16 bits; no overflow for any bit_period_i value.
REQ-028 Simultaneous push and pop SHALL leave FIFO occupancy unchanged with both words correctly ordered.

Reset
REQ-029 While rst high: tready_o=0, serial_o=0, serial_valid_o=0, packet_done_o=0, busy_o=0, FIFO emptied, FSM=IDLE.
REQ-030 Reset asserted mid-word SHALL abort the word with no further strobes; partially sent word is not resumed.
REQ-031 tready_o SHALL rise on the first edge after rst deasserts.

Configuration
REQ-032 Macro AXIS_SER_PARITY_EN: when defined, after each word's final data bit one PARITY bit SHALL be emitted (even parity over the word, same strobe spacing), then REQ-023/024 apply; when undefined, no PARITY state exists and only data bits are emitted.

Verification
REQ-033 Reset, then single word 0xA5000001 tlast=1, period 1 -> 32 consecutive strobes, bits 1,0,1,0,0,1,0,1,0...0,1; first strobe 3 cycles after accept; packet_done_o one cycle after bit 32.
REQ-034 4 words back-to-back, period 1, tlast on word 4 -> 128 strobes on consecutive cycles, no gap; single packet_done_o pulse.
REQ-035 Period 5, word 0x80000000 -> strobes every 5 cycles, first bit 1, remaining 31 bits 0; bit_period_i changed to 2 mid-word has no effect until next word.
REQ-036 FIFO_DEPTH=8, tvalid_i held high with period 4 -> tready_o drops after 8 (+1 in-flight) words accepted, rises after each pop; output word order matches input.
REQ-037 rst pulsed after 10 strobes of a word -> no further strobes, busy_o=0, tready_o=1 one cycle after release, next word serialized from its MSB.
REQ-038 With AXIS_SER_PARITY_EN, word 0x00000007 -> 33 strobes, 33rd bit 1; word 0x00000003 -> 33rd bit 0.
